// File: rtl/hs_rx_bank.sv
// hs_rx_bank
//   Multi-channel bundled-data handshake receiver. Each of NUM_CH channels
//   synchronises an asynchronous request and captures the bundled data word.
//   It presents the word as a valid/ready stream and acknowledges the remote
//   talker only after the local consumer has accepted the word.
//   MODE 0 = 4-phase return-to-zero, MODE 1 = 2-phase toggle.
//   In 4-phase mode a sticky per-channel err flags a talker that has held req
//   for TIMEOUT cycles after ack was raised.
//
// Ports
//   clk        receive-domain clock
//   reset      synchronous, active-low reset
//   req_in     [NUM_CH]        async request per channel
//   data_in    [NUM_CH*WIDTH]  bundled data, channel i = [i*WIDTH +: WIDTH]
//   ack_out    [NUM_CH]        registered acknowledge to the talker
//   rcv_valid  [NUM_CH]        captured word available
//   rcv_data   [NUM_CH*WIDTH]  captured word, stable while rcv_valid
//   rcv_ready  [NUM_CH]        consumer accepts when rcv_valid & rcv_ready
//   err        [NUM_CH]        sticky ack-phase timeout flag
//   err_clr    [NUM_CH]        clear err (a simultaneous set wins)

module hs_rx_bank #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_in,
  input  logic [NUM_CH*WIDTH-1:0]   data_in,
  output logic [NUM_CH-1:0]         ack_out,
  output logic [NUM_CH-1:0]         rcv_valid,
  output logic [NUM_CH*WIDTH-1:0]   rcv_data,
  input  logic [NUM_CH-1:0]         rcv_ready,
  output logic [NUM_CH-1:0]         err,
  input  logic [NUM_CH-1:0]         err_clr
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  // The timeout only exists in 4-phase mode; 2-phase never enters ACK.
  localparam bit TO_EN = (MODE == 0) && (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q;
    logic                   ack_q;
    logic                   valid_q;
    logic                   err_q;
    logic [WIDTH-1:0]       data_q;
    logic [TW-1:0]          timer_q;
    logic [TW-1:0]          timer_d;
    logic                   new_req;
    logic                   accept;
    logic                   err_set;

    // req_in is only ever observed through this chain.
    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], req_in[i]};
      end
    end

    always_comb begin
      new_req = 1'b0;
      if (MODE == 0) begin
        new_req = req_s;
      end else begin
        // 2-phase: a request is pending whenever req and ack disagree.
        new_req = req_s ^ ack_q;
      end
      accept  = valid_q & rcv_ready[i];
      timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
      err_set = TO_EN && (state_q == ST_ACK) && (timer_q == TMAX);
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        ack_q   <= 1'b0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
        timer_q <= '0;
      end else begin
        if (err_set) begin
          err_q <= 1'b1;
        end else if (err_clr[i]) begin
          err_q <= 1'b0;
        end

        case (state_q)
          ST_IDLE: begin
            timer_q <= '0;
            if (new_req) begin
              data_q  <= data_in[i*WIDTH +: WIDTH];
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            timer_q <= '0;
            if (accept) begin
              valid_q <= 1'b0;
              if (MODE == 0) begin
                ack_q   <= 1'b1;
                state_q <= ST_ACK;
              end else begin
                ack_q   <= ~ack_q;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_ACK: begin
            if (!req_s) begin
              ack_q   <= 1'b0;
              timer_q <= '0;
              state_q <= ST_IDLE;
            end else begin
              // Stays in ACK after a timeout; err is the only consequence.
              timer_q <= timer_d;
            end
          end
          default: begin
            timer_q <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end

    assign ack_out[i]                  = ack_q;
    assign rcv_valid[i]                = valid_q;
    assign rcv_data[i*WIDTH +: WIDTH]  = data_q;
    assign err[i]                      = err_q;
  end

endmodule

// File: tb/tb_hs_rx_bank.sv
// Directed bench for hs_rx_bank. Three instances share clk/reset:
//   A: 4-phase, TIMEOUT=4   B: 2-phase   C: 4-phase, default TIMEOUT=255

module tb_hs_rx_bank;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_req, a_ack, a_valid, a_ready, a_err, a_clr;
  logic [31:0] a_data, a_rdata;
  logic [3:0]  b_req, b_ack, b_valid, b_ready, b_err, b_clr;
  logic [31:0] b_data, b_rdata;
  logic [3:0]  c_req, c_ack, c_valid, c_ready, c_err, c_clr;
  logic [31:0] c_data, c_rdata;

  int total = 0;
  int bad   = 0;

  hs_rx_bank #(.NUM_CH(4), .WIDTH(8), .SYNC_STAGES(2), .MODE(0), .TIMEOUT(4)) u_a (
    .clk(clk), .reset(reset), .req_in(a_req), .data_in(a_data), .ack_out(a_ack),
    .rcv_valid(a_valid), .rcv_data(a_rdata), .rcv_ready(a_ready), .err(a_err), .err_clr(a_clr)
  );

  hs_rx_bank #(.NUM_CH(4), .WIDTH(8), .SYNC_STAGES(2), .MODE(1), .TIMEOUT(255)) u_b (
    .clk(clk), .reset(reset), .req_in(b_req), .data_in(b_data), .ack_out(b_ack),
    .rcv_valid(b_valid), .rcv_data(b_rdata), .rcv_ready(b_ready), .err(b_err), .err_clr(b_clr)
  );

  hs_rx_bank #(.NUM_CH(4), .WIDTH(8), .SYNC_STAGES(2), .MODE(0), .TIMEOUT(255)) u_c (
    .clk(clk), .reset(reset), .req_in(c_req), .data_in(c_data), .ack_out(c_ack),
    .rcv_valid(c_valid), .rcv_data(c_rdata), .rcv_ready(c_ready), .err(c_err), .err_clr(c_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_req = '0; a_data = '0; a_ready = '0; a_clr = '0;
    b_req = '0; b_data = '0; b_ready = '0; b_clr = '0;
    c_req = '0; c_data = '0; c_ready = '0; c_clr = '0;

    // Reset state
    tick(); tick();
    chk("rst_a_ack", a_ack, 4'h0);
    chk("rst_a_valid", a_valid, 4'h0);
    chk("rst_a_data", a_rdata, 32'h0);
    chk("rst_a_err", a_err, 4'h0);
    chk("rst_b_ack", b_ack, 4'h0);
    chk("rst_b_valid", b_valid, 4'h0);
    chk("rst_c_valid", c_valid, 4'h0);
    reset = 1'b1;

    // 1: 4-phase capture latency and hold
    a_req = 4'b0001; a_data = 32'h0000_00A5;
    tick(); chk("t1_valid_clk1", a_valid, 4'h0);
    tick(); chk("t1_valid_clk2", a_valid, 4'h0);
    tick(); chk("t1_valid_clk3", a_valid, 4'b0001);
    chk("t1_data", a_rdata, 32'h0000_00A5);
    chk("t1_ack", a_ack, 4'h0);
    a_data = 32'h0000_005A;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_hold_valid", a_valid, 4'b0001);
      chk("t1_hold_data", a_rdata, 32'h0000_00A5);
    end

    // 2: accept, ack, return to zero
    a_ready = 4'b0001;
    tick(); a_ready = '0;
    chk("t2_valid_drop", a_valid, 4'h0);
    chk("t2_ack_rise", a_ack, 4'b0001);
    a_req = '0;
    tick(); chk("t2_ack_hold1", a_ack, 4'b0001);
    tick(); chk("t2_ack_hold2", a_ack, 4'b0001);
    tick(); chk("t2_ack_fall", a_ack, 4'h0);
    chk("t2_err", a_err, 4'h0);
    tick(); chk("t2_idle_valid", a_valid, 4'h0);

    // 4: timeout with TIMEOUT=4, set-wins, sticky, clear
    a_req = 4'b0001; a_data = 32'h0000_003C;
    tick(); tick(); tick();
    chk("t4_valid", a_valid, 4'b0001);
    chk("t4_data", a_rdata, 32'h0000_003C);
    a_ready = 4'b0001;
    tick(); a_ready = '0;
    chk("t4_ack", a_ack, 4'b0001);
    tick(); tick(); tick(); tick();
    chk("t4_err_clk4", a_err, 4'h0);
    tick(); chk("t4_err_clk5", a_err, 4'b0001);
    a_clr = 4'b0001;
    tick(); a_clr = '0;
    chk("t4_set_wins", a_err, 4'b0001);
    chk("t4_still_ack", a_ack, 4'b0001);
    a_req = '0;
    tick(); tick(); tick();
    chk("t4_ack_fall", a_ack, 4'h0);
    chk("t4_err_sticky", a_err, 4'b0001);
    a_clr = 4'b0001;
    tick(); a_clr = '0;
    chk("t4_err_clr", a_err, 4'h0);
    tick(); chk("t4_err_stays0", a_err, 4'h0);
    chk("t4_idle_valid", a_valid, 4'h0);

    // 3: 2-phase toggles on channel 1
    b_ready = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      b_req = b_req ^ 4'b0010;
      b_data = 32'(k) << 8;
      tick(); tick();
      chk("t3_valid_early", b_valid, 4'h0);
      tick();
      chk("t3_valid", b_valid, 4'b0010);
      chk("t3_data", b_rdata, 32'(k) << 8);
      tick();
      chk("t3_valid_drop", b_valid, 4'h0);
      chk("t3_ack", b_ack, (k % 2 == 1) ? 4'b0010 : 4'b0000);
    end
    tick(); tick();
    chk("t3_ack_final", b_ack, 4'b0010);
    chk("t3_no_repeat", b_valid, 4'h0);
    chk("t3_err", b_err, 4'h0);

    // 5: all channels at once, accept order 3,0,2,1
    c_req = 4'b1111; c_data = 32'h4332_2110;
    tick(); tick(); tick();
    chk("t5_valid_all", c_valid, 4'b1111);
    chk("t5_data_all", c_rdata, 32'h4332_2110);
    c_data = '0;
    c_ready = 4'b1000; tick(); c_ready = '0;
    chk("t5_v_a3", c_valid, 4'b0111); chk("t5_k_a3", c_ack, 4'b1000);
    c_ready = 4'b0001; tick(); c_ready = '0;
    chk("t5_v_a0", c_valid, 4'b0110); chk("t5_k_a0", c_ack, 4'b1001);
    c_ready = 4'b0100; tick(); c_ready = '0;
    chk("t5_v_a2", c_valid, 4'b0010); chk("t5_k_a2", c_ack, 4'b1101);
    chk("t5_data_held", c_rdata, 32'h4332_2110);
    c_ready = 4'b0010; tick(); c_ready = '0;
    chk("t5_v_a1", c_valid, 4'b0000); chk("t5_k_a1", c_ack, 4'b1111);
    c_req = '0;
    tick(); tick(); chk("t5_ack_hold", c_ack, 4'b1111);
    tick(); chk("t5_ack_fall", c_ack, 4'h0);
    chk("t5_err", c_err, 4'h0);

    // 6: reset during HOLD (ch0) and ACK (ch1), re-delivery after release
    c_req = 4'b0011; c_data = 32'h0000_8877;
    tick(); tick(); tick();
    chk("t6_valid", c_valid, 4'b0011);
    c_ready = 4'b0010; tick(); c_ready = '0;
    chk("t6_ack_pre", c_ack, 4'b0010);
    chk("t6_valid_pre", c_valid, 4'b0001);
    b_ready = '0;
    reset = 1'b0;
    tick();
    chk("t6_rst_ack", c_ack, 4'h0);
    chk("t6_rst_valid", c_valid, 4'h0);
    chk("t6_rst_data", c_rdata, 32'h0);
    chk("t6_rst_err", c_err, 4'h0);
    chk("t6_rst_b_ack", b_ack, 4'h0);
    reset = 1'b1;
    tick(); tick();
    chk("t6_early_c", c_valid, 4'h0);
    chk("t6_early_b", b_valid, 4'h0);
    tick();
    chk("t6_redeliver_c", c_valid, 4'b0011);
    chk("t6_redeliver_cdata", c_rdata, 32'h0000_8877);
    chk("t6_redeliver_b", b_valid, 4'b0010);
    chk("t6_redeliver_bdata", b_rdata, 32'h0000_0300);
    chk("t6_a_idle", a_valid, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
